// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RISC-V IF stage: in-order imem fetch, PC/instruction queue, redirect flush; FETCH_PERF_EN adds perf counters
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] Instruction,
    output logic [31:0] PC_IF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_drop
`endif
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic          accept;
    logic          rsp;
    logic          drop;
    logic          push;
    logic          pop;
    logic [CW:0]   in_use;
    logic [CW-1:0] out_after_rsp;
    logic [31:0]   redirect_target;

    // Requests reserve queue space up front, so a response can never overflow the queue.
    always_comb begin
        in_use          = {1'b0, count} + {1'b0, outstanding};
        imem_req        = !reset && !redirect_valid && (in_use < (CW+1)'(DEPTH));
        accept          = imem_req && imem_ready;
        rsp             = imem_rvalid && (outstanding != '0);
        drop            = rsp && (redirect_valid || (drop_cnt != '0));
        push            = rsp && !drop;
        inst_valid      = (count != '0) && !reset;
        pop             = inst_valid && !id_stall && !redirect_valid;
        out_after_rsp   = outstanding - CW'(rsp);
        redirect_target = redirect_pc & ~32'd3;
    end

    assign imem_addr   = fetch_pc;
    assign Instruction = inst_valid ? q_inst[rd_ptr] : NOP;
    assign PC_IF       = inst_valid ? q_pc[rd_ptr] : 32'h0000_0000;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= out_after_rsp + CW'(accept);
            if (redirect_valid) begin
                // Every request still in flight belongs to the old path.
                fetch_pc <= redirect_target;
                resp_pc  <= redirect_target;
                drop_cnt <= out_after_rsp;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= resp_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_bubble <= '0;
            perf_drop   <= '0;
        end else begin
            if (!inst_valid && !id_stall && (perf_bubble != '1))
                perf_bubble <= perf_bubble + 32'd1;
            if (drop && (perf_drop != '1))
                perf_drop <= perf_drop + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with memory model and in-order PC scoreboard
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] Instruction;
    logic [31:0] PC_IF;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubble;
    logic [31:0] perf_drop;
    logic [31:0] drop_snap;
`endif

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mem_rsp_t;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          last_due = 0;
    logic [31:0] model_pc;
    logic        force_rvalid;
    mem_rsp_t    mem_q[$];
    logic [31:0] exp_q[$];

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clock(clock),
        .reset(reset),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_stall(id_stall),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .Instruction(Instruction),
        .PC_IF(PC_IF)
`ifdef FETCH_PERF_EN
        ,
        .perf_bubble(perf_bubble),
        .perf_drop(perf_drop)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0093;
            32'h0000_0004: return 32'h0010_0113;
            default:       return a ^ 32'h1234_5673;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present this cycle's memory response, then let combinational outputs settle.
    task automatic settle();
        if (force_rvalid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h0BAD_0BAD;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    // Score pops and accepts against the model, then move to the next cycle.
    task automatic advance();
        logic [31:0] e;
        mem_rsp_t    r;
        if (reset) begin
            exp_q.delete();
            mem_q.delete();
            last_due = cyc;
            model_pc = RESET_PC;
        end else begin
            if (imem_req)
                chk("imem_addr", imem_addr, model_pc);
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc & ~32'd3;
            end else begin
                if (inst_valid && !id_stall) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                    chk("pc_if", PC_IF, e);
                    chk("instruction", Instruction, mem_word(e));
                end
                if (imem_req && imem_ready) begin
                    last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    r.due  = last_due;
                    r.addr = model_pc;
                    mem_q.push_back(r);
                    exp_q.push_back(model_pc);
                    model_pc = model_pc + 32'd4;
                end
            end
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
        imem_ready = 1'b1; force_rvalid = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        model_pc = RESET_PC;
        @(negedge clock);
        run(1);
        settle();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_instruction", Instruction, 32'h0000_0013);
        chk("rst_pc_if", PC_IF, 0);
        advance();

        reset = 1'b0;
        settle(); chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 32'h0); advance();
        settle(); chk("c1_addr", imem_addr, 32'h4); chk("c1_inst_valid", inst_valid, 0); advance();
        settle();
        chk("c2_inst_valid", inst_valid, 1);
        chk("c2_pc_if", PC_IF, 32'h0);
        chk("c2_instruction", Instruction, 32'h0000_0093);
        chk("c2_req_full", imem_req, 0);
        advance();
        settle(); chk("c3_addr", imem_addr, 32'h8); advance();
        run(3);

        id_stall = 1'b1;
        run(5);
        settle(); chk("stall_req_off", imem_req, 0); chk("stall_inst_valid", inst_valid, 1); advance();
        id_stall = 1'b0;
        run(6);

        redirect_valid = 1'b1; redirect_pc = 32'h20;
        settle(); chk("redir_req_off", imem_req, 0); advance();
        redirect_valid = 1'b0; imem_ready = 1'b0;
        repeat (4) begin
            settle(); chk("hold_req", imem_req, 1); chk("hold_addr", imem_addr, 32'h20); advance();
        end
        imem_ready = 1'b1;
        settle(); chk("resume_addr", imem_addr, 32'h20); advance();
        run(5);

        lat = 3;
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        run(1);
        redirect_valid = 1'b0;
        settle(); chk("l3_addr0", imem_addr, 32'h10); advance();
        settle(); chk("l3_addr1", imem_addr, 32'h14); advance();
`ifdef FETCH_PERF_EN
        drop_snap = perf_drop;
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        run(1);
        redirect_valid = 1'b0;
        settle(); chk("l3_req_wait", imem_req, 0); chk("l3_next_addr", imem_addr, 32'h100); advance();
        run(10);
`ifdef FETCH_PERF_EN
        chk("perf_drop_delta", perf_drop - drop_snap, 2);
`endif

        lat = 1;
        run(8);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        run(1);
        redirect_valid = 1'b0;
        run(2);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        settle();
        chk("rr_pre_inst_valid", inst_valid, 1);
        chk("rr_pre_rvalid", imem_rvalid, 1);
        chk("rr_pre_pc_if", PC_IF, 32'h40);
        advance();
        redirect_valid = 1'b0;
        settle(); chk("rr_inst_valid_after", inst_valid, 0); advance();
        run(6);

        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        run(1);
        redirect_valid = 1'b0;
        settle(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); advance();
        settle(); chk("wrap_addr1", imem_addr, 32'h0); advance();
        run(4);

        reset = 1'b1;
        repeat (2) begin
            settle(); chk("mid_rst_inst_valid", inst_valid, 0); chk("mid_rst_req", imem_req, 0); advance();
        end
        reset = 1'b0; force_rvalid = 1'b1;
        settle();
        chk("post_rst_inst_valid", inst_valid, 0);
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, RESET_PC);
        advance();
        force_rvalid = 1'b0;
        settle(); chk("stale_ignored", inst_valid, 0); advance();
        run(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction Fetch stage of the 32-bit RISC-V 5-stage pipeline.
- Issues in-order word fetches to instruction memory through a request/response handshake.
- Buffers returned words with their PCs in a small queue, then presents Instruction/PC_IF plus a valid flag to the decode stage.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 2, queue entries; power of two, >=2; also bounds queued + in-flight words

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high
redirect_valid  input  1  taken branch/jump from EX; flush and refetch
redirect_pc  input  32  redirect target; bits [1:0] forced to 0
id_stall  input  1  decode not accepting this cycle
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch word address
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid; in order, latency >=1
imem_rdata  input  32  response instruction word
inst_valid  output  1  queue head valid (drives decode hit)
Instruction  output  32  queue head instruction
PC_IF  output  32  queue head PC

Behaviour:
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, Instruction 32'h0000_0013 (NOP), PC_IF 0. Queue empty; outstanding 0; drop count 0; fetch_pc = resp_pc = RESET_PC.
- Reset mid-operation discards the queue and all in-flight state. Responses arriving after reset for pre-reset requests are ignored: the ignore rule below applies because outstanding is 0.
- Issue:
  - imem_req = !reset && !redirect_valid && (queued + outstanding) < DEPTH.
  - imem_addr = fetch_pc.
  - Accept = imem_req && imem_ready. On accept: fetch_pc += 4, outstanding += 1.
  - While imem_req is high and not accepted, imem_addr is held stable. imem_req may drop unaccepted only because of redirect_valid.
- Response:
  - imem_rvalid decrements outstanding.
  - If drop count > 0, the response is discarded and drop count -= 1.
  - Otherwise {resp_pc, imem_rdata} is pushed to the queue and resp_pc += 4.
  - imem_rvalid with outstanding 0 is ignored.
  - Overflow is impossible because issue reserves queue space.
- Output / dequeue:
  - inst_valid = queue non-empty. Instruction/PC_IF show the head entry, or NOP/0 when empty.
  - Pop when inst_valid && !id_stall.
  - Push and pop in the same cycle are both honoured. Wrap-around uses log2(DEPTH)-bit pointers plus a count.
  - First-word latency from reset: accept in cycle 0, data valid at rvalid cycle +1 (registered queue).
- Redirect (priority over everything):
  - The queue is flushed; any pop that cycle is void, and inst_valid is 0 the next cycle.
  - fetch_pc = resp_pc = redirect_pc & ~3.
  - Drop count = outstanding after this cycle's response, i.e. every request accepted before the redirect.
  - A response arriving in the redirect cycle is discarded.
  - Back-to-back redirects reload the drop count from the current outstanding count each time.
- Arithmetic: PC increments are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds output ports perf_bubble [31:0] and perf_drop [31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_bubble counts cycles with inst_valid=0 and id_stall=0.
  - perf_drop counts discarded responses.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then imem_ready=1 with 1-cycle memory returning 32'h0000_0093 at PC 0 and 32'h0010_0113 at PC 4 -> imem_addr sequence 0,4,8; first inst_valid=1 with PC_IF=0 and Instruction=32'h0000_0093; consecutive pops give PC_IF 0,4,8.
- id_stall=1 for 6 cycles with DEPTH=2 -> at most 2 words queued plus in-flight; imem_req deasserts; after release, PC_IF continues 8,12 with no skips or duplicates.
- Memory latency 3 with 2 outstanding at PCs 0x10 and 0x14, then redirect_valid with redirect_pc=0x103 -> both old responses discarded (perf_drop=2 when enabled); next imem_addr=0x100; first delivered PC_IF=0x100.
- redirect_valid in the same cycle as imem_rvalid and a pop -> the response is discarded, the pop is void, and inst_valid=0 the next cycle.
- imem_ready low for 4 cycles at fetch_pc=0x20 -> imem_addr held at 0x20, no accept counted, fetch continues at 0x20 once ready rises.
- Redirect to 32'hFFFF_FFFC -> PC_IF sequence FFFF_FFFC, 0000_0000; assert reset mid-stream -> the next fetch is at RESET_PC and inst_valid=0 during and immediately after reset.
